// File: rtl/disparity_pkg.sv
// Shared constants and pixel record for the disparity decimation path.
// Downstream framers reuse disp_pix_t to carry one decimated pixel.
package disparity_pkg;
  localparam int DECIMATE_FACTOR = 2;
  localparam int FRAME_W         = 240;
  localparam int FRAME_H         = 240;
  localparam int DISPARITY_BITS  = 5;

  localparam int OUT_W = FRAME_W / DECIMATE_FACTOR;
  localparam int OUT_H = FRAME_H / DECIMATE_FACTOR;
  localparam int CNT_W = $clog2(DECIMATE_FACTOR * DECIMATE_FACTOR + 1);
  localparam int X_W   = $clog2(OUT_W);
  localparam int Y_W   = $clog2(OUT_H);

  typedef struct packed {
    logic [7:0]       disp;
    logic [7:0]       conf;
    logic [CNT_W-1:0] ones;
    logic             keep;
    logic [X_W-1:0]   x;
    logic [Y_W-1:0]   y;
    logic             sof;
    logic             eol;
  } disp_pix_t;

  typedef enum logic {
    IDLE  = 1'b0,
    ACCUM = 1'b1
  } dd_state_e;
endpackage

// File: rtl/popcount_n.sv
// Combinational population count of a width-bit vector.
module popcount_n #(
  parameter int width = 2
) (
  input  logic [width-1:0]             bits,
  output logic [$clog2(width+1)-1:0]   count
);
  localparam int CW = $clog2(width + 1);

  always_comb begin
    count = '0;
    for (int i = 0; i < width; i++)
      count = count + CW'(bits[i]);
  end
endmodule

// File: rtl/disparity_decimate_filter.sv
// Accumulates decimate_factor beats into one block popcount, gates disparity
// by count/confidence thresholds and emits one pixel with x/y and frame markers.
module disparity_decimate_filter
  import disparity_pkg::*;
#(
  parameter int decimate_factor = DECIMATE_FACTOR,
  parameter int frame_w         = FRAME_W,
  parameter int frame_h         = FRAME_H,
  parameter int disparity_bits  = DISPARITY_BITS,
  localparam int out_w  = frame_w / decimate_factor,
  localparam int out_h  = frame_h / decimate_factor,
  localparam int cnt_w  = $clog2(decimate_factor * decimate_factor + 1),
  localparam int x_w    = $clog2(out_w),
  localparam int y_w    = $clog2(out_h)
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [decimate_factor-1:0] pix_in,
  input  logic [7:0]                 conf_in,
  input  logic [7:0]                 disp_in,
  input  logic                       pix_in_valid,
  input  logic [cnt_w-1:0]           min_ones,
  input  logic [7:0]                 min_conf,
  output logic [7:0]                 disp_out,
  output logic [7:0]                 conf_out,
  output logic [cnt_w-1:0]           ones_out,
  output logic                       keep_out,
  output logic [x_w-1:0]             x_out,
  output logic [y_w-1:0]             y_out,
  output logic                       sof_out,
  output logic                       eol_out,
  output logic                       out_valid
);
  localparam int beat_w = $clog2(decimate_factor);
  localparam int pc_w   = $clog2(decimate_factor + 1);

  dd_state_e                 state, state_nxt;
  logic [beat_w-1:0]         beat;
  logic [cnt_w-1:0]          acc, sum;
  logic [pc_w-1:0]           pc;
  logic [7:0]                conf_r;
  logic [disparity_bits-1:0] disp_r;
  logic [x_w-1:0]            x_cnt;
  logic [y_w-1:0]            y_cnt;
  logic                      last_beat, keep_nxt;

  popcount_n #(.width(decimate_factor)) u_pc (
    .bits  (pix_in),
    .count (pc)
  );

  assign sum       = acc + cnt_w'(pc);
  assign last_beat = pix_in_valid && (beat == beat_w'(decimate_factor - 1));
  // Thresholds are taken live in the last-beat cycle; conf_r was latched on beat 0.
  assign keep_nxt  = (sum >= min_ones) && (conf_r >= min_conf);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (pix_in_valid) state_nxt = ACCUM;
      ACCUM:   if (last_beat)    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      beat   <= '0;
      acc    <= '0;
      conf_r <= '0;
      disp_r <= '0;
    end else if (pix_in_valid) begin
      beat <= last_beat ? '0 : beat + beat_w'(1);
      if (state == IDLE) begin
        acc    <= cnt_w'(pc);
        conf_r <= conf_in;
        disp_r <= disp_in[disparity_bits-1:0];
      end else begin
        acc <= sum;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_valid <= 1'b0;
      disp_out  <= '0;
      conf_out  <= '0;
      ones_out  <= '0;
      keep_out  <= 1'b0;
      x_out     <= '0;
      y_out     <= '0;
      sof_out   <= 1'b0;
      eol_out   <= 1'b0;
      x_cnt     <= '0;
      y_cnt     <= '0;
    end else begin
      out_valid <= last_beat;
      sof_out   <= 1'b0;
      eol_out   <= 1'b0;
      if (last_beat) begin
        ones_out <= sum;
        keep_out <= keep_nxt;
        disp_out <= keep_nxt ? 8'(disp_r) : 8'd0;
        conf_out <= conf_r;
        x_out    <= x_cnt;
        y_out    <= y_cnt;
        sof_out  <= (x_cnt == '0) && (y_cnt == '0);
        eol_out  <= (x_cnt == x_w'(out_w - 1));
        if (x_cnt == x_w'(out_w - 1)) begin
          x_cnt <= '0;
          y_cnt <= (y_cnt == y_w'(out_h - 1)) ? '0 : y_cnt + y_w'(1);
        end else begin
          x_cnt <= x_cnt + x_w'(1);
        end
      end
    end
  end
endmodule

// File: doc/disparity_decimate_filter.md
Name: disparity_decimate_filter

Overview:
- Sits directly downstream of the XOR row-buffer streamer. Consumes its pix_stream_data/conf/disp/valid beats, which arrive as decimate_factor beats per output pixel, each beat carrying decimate_factor horizontally adjacent XOR bits of one full-resolution row.
- Popcounts each decimate_factor x decimate_factor group and gates the block disparity with a count threshold and a confidence threshold.
- Emits one decimated disparity pixel per group, with x/y coordinates and start-of-frame/end-of-line markers, to the disparity output framer.

Parameters:
- decimate_factor, 2, full-res pixels per output pixel per axis; must be a power of 2, >= 2.
- frame_w, 240, full-res frame width.
- frame_h, 240, full-res frame height.
- disparity_bits, 5, significant bits of disp_in.
- out_w, frame_w/decimate_factor, derived output width.
- out_h, frame_h/decimate_factor, derived output height.
- cnt_w, $clog2(decimate_factor*decimate_factor+1), derived popcount width.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-low reset.
- pix_in  in  decimate_factor  XOR bits of one beat.
- conf_in  in  8  block confidence, aligned with pix_in.
- disp_in  in  8  block disparity, aligned with pix_in; bits above disparity_bits are ignored.
- pix_in_valid  in  1  beat qualifier.
- min_ones  in  cnt_w  quasi-static count threshold.
- min_conf  in  8  quasi-static confidence threshold.
- disp_out  out  8  gated disparity; 0 when rejected.
- conf_out  out  8  confidence of the group.
- ones_out  out  cnt_w  popcount of the group.
- keep_out  out  1  1 = pixel passed both thresholds.
- x_out  out  $clog2(out_w)  output column.
- y_out  out  $clog2(out_h)  output row.
- sof_out  out  1  first pixel of frame (x=0, y=0).
- eol_out  out  1  last pixel of a row (x=out_w-1).
- out_valid  out  1  single-cycle pixel strobe.

Behaviour:
- Reset (asserted low, asynchronous): clears all outputs, beat counter, accumulator and x/y counters to 0. Deassertion is synchronised by the system.
- Beat counter `beat` counts 0..decimate_factor-1 and advances only on pix_in_valid. Gaps of any length between beats are allowed; partial state is held across them.
- On beat 0: acc <= popcount(pix_in); conf_in and disp_in[disparity_bits-1:0] are latched into conf_r and disp_r. Later beats' conf/disp are ignored (constant within a block).
- On beats 1..decimate_factor-2: acc <= acc + popcount(pix_in).
- On beat decimate_factor-1 (cycle N): the final sum s = acc + popcount(pix_in) is formed combinationally.
- Registered outputs at N+1, latency 1 cycle from the last beat:
  - out_valid = 1 for exactly one cycle.
  - ones_out = s.
  - keep_out = (s >= min_ones) && (conf_r >= min_conf).
  - disp_out = keep_out ? zero-extended disp_r : 0.
  - conf_out = conf_r always.
- Back-to-back groups give one pixel every decimate_factor cycles; no backpressure exists and none is needed.
- Coordinates: x_out and y_out carry the position of the emitted pixel.
  - After each emitted pixel, x increments. At out_w-1, x wraps to 0 and y increments.
  - At (out_w-1, out_h-1), both wrap to 0.
  - sof_out = (x==0 && y==0); eol_out = (x==out_w-1). Both are valid only with out_valid.
- Between pixels: out_valid = 0. disp/conf/ones/keep/x/y hold their last values; sof/eol are 0.
- Threshold inputs are sampled in the cycle of the last beat; a change mid-group is legal.
- min_ones = 0 with min_conf = 0 keeps every pixel. min_ones > decimate_factor^2 rejects every pixel.
- State machine, 2 states:
  - IDLE (beat==0, no partial group) -> ACCUM on a valid beat 0.
  - ACCUM -> IDLE on the last valid beat, which emits the pixel.
  - For decimate_factor==2, ACCUM holds one beat.
- Reset mid-group discards the partial group; the next valid beat is treated as beat 0, and x/y restart at 0.

Decomposition:
- Shared package disparity_pkg holds constants DECIMATE_FACTOR, FRAME_W, FRAME_H, DISPARITY_BITS and a typedef packed struct disp_pix_t {disp, conf, ones, keep, x, y, sof, eol} for downstream reuse.
- One sub-module, popcount_n (parameter width), a purely combinational adder tree, is reused by the cost filters.

Test Plan:
- Two back-to-back beats pix=2'b11, 2'b10 with conf=200, disp=17, min_ones=2, min_conf=100 -> one cycle later out_valid=1, ones_out=3, keep_out=1, disp_out=17, conf_out=200, sof_out=1, x=0, y=0.
- Same beats with conf=50 -> keep_out=0, disp_out=0, conf_out=50, ones_out=3.
- Beats 2'b00 and 2'b01 separated by a 7-cycle gap -> exactly one out_valid, ones_out=1, keep_out=0 with min_ones=2.
- Stream 2*out_w*out_h random valid beats -> out_w*out_h pixels; eol_out on every x=119; second frame restarts with sof_out at (0,0).
- Reset driven low after beat 0 of a group, then two fresh beats 2'b11, 2'b11 -> a single pixel with ones_out=4, x=0, y=0; no pixel is produced from the discarded beat.
- min_ones=5 and min_conf=0 on any input -> keep_out=0 and disp_out=0 for all pixels.
